// File: rtl/lfsr_gen.sv
// -----------------------------------------------------------------------------
// lfsr_gen
//   Parametrised pseudo-random sequence generator. Fibonacci or Galois mode is
//   selected at run time. The tap mask is programmable. A rate divider paces
//   free-running advances, and a single-step strobe forces one advance.
//   Other features:
//     - seed loading, with all-ones substituted for a zero seed
//     - lock-up recovery, so the state never becomes zero
//     - sequence-period measurement against the last loaded seed
//
// Parameters
//   WIDTH     register width (3..32)
//   DIV       clock cycles per free-run advance (>= 1)
//   RST_TAPS  tap mask loaded at reset
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   enable        free-run enable (gates the rate divider)
//   step          one-cycle strobe, one advance regardless of enable
//   mode          0 = Fibonacci, 1 = Galois
//   taps_we       tap mask write strobe
//   taps_in       new tap mask
//   seed_load     load seed into the state and the period reference
//   seed          seed value
//   q             current state
//   adv_o         pulse in the cycle after q changed by an advance
//   lockup        pulse: an all-zero next state was replaced by all ones
//   seed_err      pulse: a zero seed was replaced by all ones
//   period        last measured sequence length
//   period_valid  pulse when period updates
// -----------------------------------------------------------------------------
module lfsr_gen #(
   parameter int               WIDTH    = 8,
   parameter int               DIV      = 33554432,
   parameter logic [WIDTH-1:0] RST_TAPS = WIDTH'(8'hB4)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             step,
   input  logic             mode,
   input  logic             taps_we,
   input  logic [WIDTH-1:0] taps_in,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] q,
   output logic             adv_o,
   output logic             lockup,
   output logic             seed_err,
   output logic [WIDTH-1:0] period,
   output logic             period_valid
);

   // The divider counts 0..DIV-1, so it needs ceil(log2(DIV)) bits, and at
   // least one bit when DIV == 1.
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_taps;
   logic [WIDTH-1:0] r_seed_ref;
   logic [WIDTH-1:0] r_step_cnt;
   logic [WIDTH-1:0] r_period;
   logic [DIV_W-1:0] r_div_cnt;
   logic             r_adv;
   logic             r_lockup;
   logic             r_seed_err;
   logic             r_period_valid;

   logic             w_tick;
   logic             w_adv;
   logic             w_fib_fb;
   logic [WIDTH-1:0] w_fib_next;
   logic [WIDTH-1:0] w_gal_next;
   logic [WIDTH-1:0] w_next;
   logic             w_lock;
   logic [WIDTH-1:0] w_new_q;
   logic             w_seed_zero;
   logic [WIDTH-1:0] w_seed_val;
   logic             w_hit_ref;

   assign w_tick = enable && (r_div_cnt == DIV_LAST);
   assign w_adv  = w_tick | step;

   // Fibonacci: shift left and insert the parity of the tapped bits at bit 0.
   assign w_fib_fb   = ^(r_q & r_taps);
   assign w_fib_next = {r_q[WIDTH-2:0], w_fib_fb};

   // Galois: shift left and rotate the MSB into bit 0. When the MSB is set,
   // it is also XORed into every bit i whose tap bit i-1 is set.
   assign w_gal_next = {r_q[WIDTH-2:0], r_q[WIDTH-1]}
                     ^ ({r_taps[WIDTH-2:0], 1'b0} & {WIDTH{r_q[WIDTH-1]}});

   assign w_next    = mode ? w_gal_next : w_fib_next;
   assign w_lock    = (w_next == '0);
   assign w_new_q   = w_lock ? ALL_ONES : w_next;
   assign w_hit_ref = (w_new_q == r_seed_ref);

   assign w_seed_zero = (seed == '0);
   assign w_seed_val  = w_seed_zero ? ALL_ONES : seed;

   // NOTE: every register here is updated with non-blocking assignments, so
   // all right-hand sides see pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q            <= ALL_ONES;
         r_taps         <= RST_TAPS;
         r_seed_ref     <= ALL_ONES;
         r_div_cnt      <= '0;
         r_step_cnt     <= '0;
         r_period       <= '0;
         r_adv          <= 1'b0;
         r_lockup       <= 1'b0;
         r_seed_err     <= 1'b0;
         r_period_valid <= 1'b0;
      end else begin
         // Pulses default low and are raised only by the event that owns them.
         r_adv          <= 1'b0;
         r_lockup       <= 1'b0;
         r_seed_err     <= 1'b0;
         r_period_valid <= 1'b0;

         // Tap writes are independent of seed loading and advancing.
         if (taps_we) begin
            r_taps <= taps_in;
         end

         if (seed_load) begin
            r_div_cnt <= '0;
         end else if (enable) begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
         end

         if (seed_load) begin
            r_q        <= w_seed_val;
            r_seed_ref <= w_seed_val;
            r_seed_err <= w_seed_zero;
            r_step_cnt <= '0;
         end else if (w_adv) begin
            r_q      <= w_new_q;
            r_adv    <= 1'b1;
            r_lockup <= w_lock;
            // step_cnt holds the advances already taken, so the advance that
            // returns to the reference state closes a period of step_cnt + 1.
            if (w_hit_ref) begin
               r_period       <= r_step_cnt + WIDTH'(1);
               r_period_valid <= 1'b1;
               r_step_cnt     <= '0;
            end else begin
               r_step_cnt <= r_step_cnt + WIDTH'(1);
            end
         end
      end
   end

   assign q            = r_q;
   assign adv_o        = r_adv;
   assign lockup       = r_lockup;
   assign seed_err     = r_seed_err;
   assign period       = r_period;
   assign period_valid = r_period_valid;

endmodule

// File: tb/tb_lfsr_gen.sv
// -----------------------------------------------------------------------------
// tb_lfsr_gen
//   Directed bench for lfsr_gen (WIDTH=8, DIV=4, RST_TAPS=8'hB4). Inputs are
//   driven and outputs sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_lfsr_gen;

   localparam int WIDTH = 8;
   localparam int DIV   = 4;

   logic             clk;
   logic             rst;
   logic             enable;
   logic             step;
   logic             mode;
   logic             taps_we;
   logic [WIDTH-1:0] taps_in;
   logic             seed_load;
   logic [WIDTH-1:0] seed;
   logic [WIDTH-1:0] q;
   logic             adv_o;
   logic             lockup;
   logic             seed_err;
   logic [WIDTH-1:0] period;
   logic             period_valid;

   int n_checks = 0;
   int n_fail   = 0;

   lfsr_gen #(
      .WIDTH   (WIDTH),
      .DIV     (DIV),
      .RST_TAPS(8'hB4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .step        (step),
      .mode        (mode),
      .taps_we     (taps_we),
      .taps_in     (taps_in),
      .seed_load   (seed_load),
      .seed        (seed),
      .q           (q),
      .adv_o       (adv_o),
      .lockup      (lockup),
      .seed_err    (seed_err),
      .period      (period),
      .period_valid(period_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance one rising edge and settle 1 ns past it.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [WIDTH-1:0] prev_q;
      logic [WIDTH-1:0] exp_q;
      int               pv_count;
      int               pv_at;

      rst       = 1'b1;
      enable    = 1'b0;
      step      = 1'b0;
      mode      = 1'b0;
      taps_we   = 1'b0;
      taps_in   = '0;
      seed_load = 1'b0;
      seed      = '0;

      // ---------------- reset state and first Fibonacci step ----------------
      cyc();
      cyc();
      check("rst q",            q,            32'hFF);
      check("rst period",       period,       32'h00);
      check("rst adv_o",        adv_o,        32'h0);
      check("rst lockup",       lockup,       32'h0);
      check("rst seed_err",     seed_err,     32'h0);
      check("rst period_valid", period_valid, 32'h0);
      rst = 1'b0;

      step = 1'b1;
      cyc();
      step = 1'b0;
      check("fib step q",      q,      32'hFE);
      check("fib step adv_o",  adv_o,  32'h1);
      check("fib step lockup", lockup, 32'h0);
      cyc();
      check("fib idle q",     q,     32'hFE);
      check("fib idle adv_o", adv_o, 32'h0);

      // ---------------- Galois step from seed 0x80 ----------------
      seed_load = 1'b1;
      seed      = 8'h80;
      cyc();
      seed_load = 1'b0;
      check("seed80 q",        q,        32'h80);
      check("seed80 seed_err", seed_err, 32'h0);
      mode = 1'b1;
      step = 1'b1;
      cyc();
      step = 1'b0;
      mode = 1'b0;
      check("galois q", q, 32'h69);

      // ---------------- divider: enable high straight from reset ----------------
      // Expected advances from 0xFF with taps 0xB4: FE, FC, F8.
      rst    = 1'b1;
      enable = 1'b1;
      cyc();
      rst    = 1'b0;
      exp_q  = 8'hFF;
      for (int n = 1; n <= 13; n++) begin
         prev_q = q;
         cyc();
         check($sformatf("div changed n=%0d", n), (q != prev_q), ((n % 4) == 0));
         check($sformatf("div adv_o n=%0d", n),   adv_o,         ((n % 4) == 0));
      end
      check("div q after 12", q, 32'hF8);
      // Edges 14, 15 idle; edge 16 is a tick and also has step high.
      cyc();
      cyc();
      step = 1'b1;
      cyc();
      step = 1'b0;
      check("tick+step q",     q,     32'hF1);
      check("tick+step adv_o", adv_o, 32'h1);
      cyc();
      cyc();
      cyc();
      check("tick+step single q", q, 32'hF1);
      enable = 1'b0;

      // ---------------- zero seed, then lock-up recovery ----------------
      seed_load = 1'b1;
      seed      = 8'h00;
      cyc();
      check("seed0 q",        q,        32'hFF);
      check("seed0 seed_err", seed_err, 32'h1);
      // Clear taps and load seed 0x01 on the same edge.
      taps_we = 1'b1;
      taps_in = 8'h00;
      seed    = 8'h01;
      cyc();
      taps_we   = 1'b0;
      seed_load = 1'b0;
      check("seed01 q",        q,        32'h01);
      check("seed01 seed_err", seed_err, 32'h0);
      step = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         cyc();
         exp_q = 8'(1 << k);
         check($sformatf("shift q k=%0d", k), q,      exp_q);
         check($sformatf("shift lk k=%0d", k), lockup, 32'h0);
      end
      cyc();
      step = 1'b0;
      check("lockup q",     q,      32'hFF);
      check("lockup pulse", lockup, 32'h1);
      check("lockup adv_o", adv_o,  32'h1);
      cyc();
      check("lockup drop", lockup, 32'h0);

      // ---------------- period measurement, taps 0xB8 ----------------
      taps_we   = 1'b1;
      taps_in   = 8'hB8;
      seed_load = 1'b1;
      seed      = 8'h01;
      cyc();
      taps_we   = 1'b0;
      seed_load = 1'b0;
      check("pre-period", period, 32'h00);
      for (int pass = 0; pass < 2; pass++) begin
         pv_count = 0;
         pv_at    = 0;
         step     = 1'b1;
         for (int k = 1; k <= 255; k++) begin
            cyc();
            if (period_valid === 1'b1) begin
               pv_count++;
               pv_at = k;
            end
         end
         step = 1'b0;
         check($sformatf("pv count p%0d", pass), pv_count, 32'd1);
         check($sformatf("pv index p%0d", pass), pv_at,    32'd255);
         check($sformatf("period p%0d", pass),   period,   32'd255);
         check($sformatf("q home p%0d", pass),   q,        32'h01);
      end
      cyc();
      check("pv drop", period_valid, 32'h0);

      // ---------------- reset mid-run drops pending activity ----------------
      // A tick at edge 4 leaves the divider part-way at edge 6.
      enable = 1'b1;
      for (int k = 0; k < 6; k++) cyc();
      rst  = 1'b1;
      step = 1'b1;
      cyc();
      rst  = 1'b0;
      step = 1'b0;
      check("mid rst q",            q,            32'hFF);
      check("mid rst period",       period,       32'h00);
      check("mid rst adv_o",        adv_o,        32'h0);
      check("mid rst period_valid", period_valid, 32'h0);
      for (int n = 1; n <= 4; n++) begin
         cyc();
         check($sformatf("post rst q n=%0d", n),   q,     (n == 4) ? 32'hFE : 32'hFF);
         check($sformatf("post rst adv n=%0d", n), adv_o, (n == 4) ? 32'h1  : 32'h0);
      end
      enable = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised pseudo-random sequence generator, the successor to the fixed 8-bit LFSR. It has configurable width, run-time programmable taps, and selectable Fibonacci or Galois mode. An internal rate divider sets the free-run rate, and a single-step strobe advances it on demand. The block adds seed loading, lock-up recovery and sequence-period measurement. It feeds LED/pattern logic and test-stimulus generators from the system clock.

## Interface
- WIDTH, 8: register width, 3..32.
- DIV, 33554432: clock cycles per free-run advance, ≥1. The default equals a tick every 2^25 cycles.
- RST_TAPS, 8'hB4: tap value loaded at reset, WIDTH bits. 8'hB4 gives feedback from bits 2, 4, 5 and 7.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  free-run enable; gates the rate divider.
- step  in  1  single-cycle strobe; one advance regardless of enable.
- mode  in  1  0 = Fibonacci, 1 = Galois.
- taps_we  in  1  write strobe for taps.
- taps_in  in  WIDTH  new tap mask.
- seed_load  in  1  load seed into the state and the period reference.
- seed  in  WIDTH  seed value.
- q  out  WIDTH  current state.
- adv_o  out  1  high for one cycle, in the cycle after q changed by an advance.
- lockup  out  1  one-cycle pulse: all-zero next state was replaced.
- seed_err  out  1  one-cycle pulse: zero seed was replaced.
- period  out  WIDTH  last measured sequence length.
- period_valid  out  1  one-cycle pulse when period updates.

## Operation
- Reset values:
  - q = all ones; taps = RST_TAPS; seed_ref = all ones.
  - div_cnt = 0; step_cnt = 0; period = 0.
  - adv_o, lockup, seed_err and period_valid = 0.
- Priority per edge: rst > seed_load > advance. taps_we is independent of all three.
- Divider:
  - With enable=1, div_cnt counts 0..DIV-1 and wraps.
  - tick = enable && div_cnt==DIV-1.
  - With enable=0, div_cnt holds.
  - seed_load clears div_cnt. DIV=1 gives a tick every enabled cycle.
- Advance condition: adv = tick | step. If both are high, the state advances once.
- Fibonacci next state:
  - fb = XOR-reduce(q & taps).
  - next = {q[WIDTH-2:0], fb}; bit 0 receives fb and bit i receives q[i-1].
- Galois next state, with o = q[WIDTH-1]:
  - next[0] = o.
  - next[i] = q[i-1] ^ (o & taps[i-1]) for i = 1..WIDTH-1.
- Lock-up recovery: if next == 0, q loads all ones instead and lockup pulses. q is never zero.
- Seed load:
  - q ← seed and seed_ref ← seed.
  - If seed == 0, both load all ones and seed_err pulses.
  - step_cnt clears. No advance happens that cycle.
- Taps and mode changes:
  - taps_we updates taps at the edge.
  - A new mode or taps value applies from the next advance.
  - Neither clears step_cnt, so the period measured after such a change is undefined until the next seed_load.
- Period measurement:
  - On each advance, step_cnt increments, wrapping at WIDTH bits.
  - If the state written into q equals seed_ref:
    - period ← step_cnt + 1 (truncated to WIDTH bits);
    - period_valid pulses;
    - step_cnt clears.
  - A maximal sequence yields period = 2^WIDTH − 1.

## Timing
- tick and step are combinational into the state update; q changes at the same edge.
- adv_o, lockup and period_valid are registered and are high in the cycle after that edge, aligned with the new q and period.
- seed_err is high in the cycle after the load edge.
- With enable held high, advances are spaced exactly DIV cycles apart.
- The first advance comes DIV cycles after reset deassertion or after a seed_load.
- rst mid-sequence restores all reset values at that edge. Pending pulses drop.
- Period: one compare per advance. No combinational path from inputs to outputs.

## Test plan
- Reset, WIDTH=8, mode=0, one step → q: 0xFF→0xFE; adv_o high for 1 cycle; lockup=0.
- Galois: seed_load 0x80, mode=1, one step → q=0x69.
- DIV=4, enable=1 from reset → q changes at cycles 4, 8, 12. step pulsed in the same cycle as a tick → exactly one advance.
- seed_load 0x00 → q=0xFF and seed_err pulses. Then taps_we with 0x00, mode=0, steps from seed 0x01 → after 8 steps the next state is 0, q becomes 0xFF and lockup pulses.
- Taps 0xB8, seed 0x01, 255 steps → period=255 with period_valid on the 255th advance, q back to 0x01. Continuing for 255 more steps gives period_valid again.
- rst asserted mid-run with DIV=4 → q=0xFF, period=0, div_cnt restarts, and the next tick comes 4 cycles after deassertion.
